// File: rtl/bitcount_unit.sv
// Multi-cycle Zbb count unit: CTZ, CLZ (via bit-reverse + CTZ) and CPOP (Kernighan).
// One op in flight; valid/ready on both sides; synchronous flush, async active-low reset.
module bitcount_unit #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned TAG_W = 5
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [XLEN-1:0]  in_rs1,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_result,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy
);

   localparam int unsigned CNT_W = 6;

   localparam logic [1:0] OP_CTZ  = 2'b00;
   localparam logic [1:0] OP_CLZ  = 2'b01;
   localparam logic [1:0] OP_CPOP = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t             r_state;
   logic [1:0]         r_op;
   logic [XLEN-1:0]    r_work;
   logic [CNT_W-1:0]   r_count;
   logic [XLEN-1:0]    r_result;
   logic [TAG_W-1:0]   r_tag;

   state_t             w_state_nxt;
   logic [1:0]         w_op_nxt;
   logic [XLEN-1:0]    w_work_nxt;
   logic [CNT_W-1:0]   w_count_nxt;
   logic [XLEN-1:0]    w_result_nxt;
   logic [TAG_W-1:0]   w_tag_nxt;

   logic [XLEN-1:0]    w_rev;
   logic [CNT_W-1:0]   w_ctz;

   // Bit-reverse the incoming operand so CLZ can reuse the trailing-zero counter.
   always_comb begin
      w_rev = '0;
      for (int i = 0; i < int'(XLEN); i++) begin
         w_rev[i] = in_rs1[int'(XLEN) - 1 - i];
      end
   end

   // Single-cycle trailing-zero counter on the work register; all-zero yields XLEN.
   always_comb begin
      w_ctz = CNT_W'(XLEN);
      for (int i = int'(XLEN) - 1; i >= 0; i--) begin
         if (r_work[i]) begin
            w_ctz = CNT_W'(i);
         end
      end
   end

   // Next-state and datapath update; flush dominates every state.
   always_comb begin
      w_state_nxt  = r_state;
      w_op_nxt     = r_op;
      w_work_nxt   = r_work;
      w_count_nxt  = r_count;
      w_result_nxt = r_result;
      w_tag_nxt    = r_tag;

      if (flush) begin
         w_state_nxt = ST_IDLE;
         w_count_nxt = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  w_op_nxt    = in_op;
                  w_tag_nxt   = in_tag;
                  w_work_nxt  = (in_op == OP_CLZ) ? w_rev : in_rs1;
                  w_count_nxt = '0;
                  w_state_nxt = ST_CALC;
               end
            end
            ST_CALC: begin
               if ((r_op == OP_CTZ) || (r_op == OP_CLZ)) begin
                  w_result_nxt = XLEN'(w_ctz);
                  w_state_nxt  = ST_DONE;
               end else if (r_op == OP_CPOP) begin
                  // Clear the lowest set bit per cycle until nothing is left.
                  if (r_work != '0) begin
                     w_work_nxt  = r_work & (r_work - XLEN'(1));
                     w_count_nxt = r_count + CNT_W'(1);
                  end else begin
                     w_result_nxt = XLEN'(r_count);
                     w_state_nxt  = ST_DONE;
                  end
               end else begin
                  w_result_nxt = '0;
                  w_state_nxt  = ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  w_state_nxt = ST_IDLE;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= ST_IDLE;
         r_op     <= '0;
         r_work   <= '0;
         r_count  <= '0;
         r_result <= '0;
         r_tag    <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_op     <= w_op_nxt;
         r_work   <= w_work_nxt;
         r_count  <= w_count_nxt;
         r_result <= w_result_nxt;
         r_tag    <= w_tag_nxt;
      end
   end

   assign in_ready   = (r_state == ST_IDLE) & ~flush;
   assign out_valid  = (r_state == ST_DONE);
   assign busy       = (r_state != ST_IDLE);
   assign out_result = r_result;
   assign out_tag    = r_tag;

endmodule

// File: tb/tb_bitcount_unit.sv
// Self-checking bench for bitcount_unit: directed cases plus random ops vs. an arithmetic model.
module tb_bitcount_unit;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_op;
   logic [31:0] in_rs1;
   logic [4:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [4:0]  out_tag;
   logic        busy;

   int n_cmp = 0;
   int n_err = 0;

   bitcount_unit #(.XLEN(32), .TAG_W(5)) dut (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_rs1(in_rs1), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_tag(out_tag), .busy(busy)
   );

   always #5 clk = ~clk;

   // Reference model: counts derived directly from the bit-level definitions.
   function automatic int ref_ctz(input logic [31:0] x);
      int n = 0;
      if (x == 32'd0) return 32;
      while (!x[n]) n++;
      return n;
   endfunction

   function automatic int ref_clz(input logic [31:0] x);
      int n = 0;
      if (x == 32'd0) return 32;
      while (!x[31 - n]) n++;
      return n;
   endfunction

   function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] x);
      case (op)
         2'b00:   return 32'(ref_ctz(x));
         2'b01:   return 32'(ref_clz(x));
         2'b10:   return 32'($countones(x));
         default: return 32'd0;
      endcase
   endfunction

   function automatic int ref_calc_cycles(input logic [1:0] op, input logic [31:0] x);
      return (op == 2'b10) ? $countones(x) + 1 : 1;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present an op for one cycle; in_ready must be high so the handshake happens.
   task automatic issue(input logic [1:0] op, input logic [31:0] x, input logic [4:0] tag);
      in_valid = 1'b1; in_op = op; in_rs1 = x; in_tag = tag;
      check("in_ready_before_issue", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      in_rs1 = $urandom;
   endtask

   // Wait for out_valid, returning the number of CALC cycles spent (bounded).
   task automatic wait_done(output int k);
      k = 0;
      while (!out_valid && k < 100) begin
         step();
         k++;
      end
      if (!out_valid) check("wait_done_timeout", 32'd0, 32'd1);
   endtask

   task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] x,
                         input logic [4:0] t);
      int k;
      issue(op, x, t);
      wait_done(k);
      check({tag, "_cycles"}, 32'(k), 32'(ref_calc_cycles(op, x)));
      check({tag, "_result"}, out_result, ref_result(op, x));
      check({tag, "_tag"}, 32'(out_tag), 32'(t));
      check({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
      check({tag, "_busy_drop"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int k;
      logic [31:0] held_res;
      logic [4:0]  held_tag;
      logic [1:0]  rop;
      logic [31:0] rx;
      int seen_valid;

      reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = 2'b00;
      in_rs1 = 32'd0; in_tag = 5'd0; out_ready = 1'b0;
      step();
      step();
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_result", out_result, 32'd0);
      check("rst_out_tag", 32'(out_tag), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      #3 reset_n = 1'b1;
      step();

      // First-op latency: out_valid two cycles after the handshake cycle.
      run_op("ctz_100", 2'b00, 32'h0000_0100, 5'd5);
      run_op("clz_10000", 2'b01, 32'h0001_0000, 5'd1);
      run_op("clz_msb", 2'b01, 32'h8000_0000, 5'd2);
      run_op("clz_zero", 2'b01, 32'h0000_0000, 5'd3);
      run_op("ctz_zero", 2'b00, 32'h0000_0000, 5'd4);
      run_op("ctz_msb", 2'b00, 32'h8000_0000, 5'd6);
      run_op("cpop_f0", 2'b10, 32'hF0F0_F0F0, 5'd7);
      run_op("cpop_zero", 2'b10, 32'h0000_0000, 5'd8);
      run_op("cpop_ones", 2'b10, 32'hFFFF_FFFF, 5'd9);
      run_op("reserved", 2'b11, 32'h1234_5678, 5'd10);

      // Backpressure: result held for 5 cycles, competing in_valid ignored.
      issue(2'b01, 32'h0000_0400, 5'd11);
      wait_done(k);
      held_res = out_result;
      held_tag = out_tag;
      check("bp_result", held_res, 32'd21);
      in_valid = 1'b1; in_op = 2'b00; in_rs1 = 32'h0000_0001; in_tag = 5'd12;
      for (int i = 0; i < 5; i++) begin
         check("bp_in_ready", 32'(in_ready), 32'd0);
         step();
         check("bp_valid_held", 32'(out_valid), 32'd1);
         check("bp_result_held", out_result, held_res);
         check("bp_tag_held", 32'(out_tag), 32'(held_tag));
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("bp_idle", 32'(busy), 32'd0);
      // The waiting op is accepted now, one cycle after returning to IDLE.
      check("bp_next_ready", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      check("bp_next_busy", 32'(busy), 32'd1);
      wait_done(k);
      check("bp_next_result", out_result, 32'd0);
      check("bp_next_tag", 32'(out_tag), 32'd12);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;

      // Flush in the 4th CALC cycle; simultaneous in_valid must not be taken.
      issue(2'b10, 32'hFFFF_FFFF, 5'd13);
      step();
      step();
      step();
      check("fl_busy_pre", 32'(busy), 32'd1);
      flush = 1'b1;
      in_valid = 1'b1; in_op = 2'b00; in_rs1 = 32'h0000_0010; in_tag = 5'd14;
      check("fl_in_ready", 32'(in_ready), 32'd0);
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      check("fl_idle", 32'(busy), 32'd1 - 32'd1);
      seen_valid = 0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid) seen_valid++;
         step();
      end
      check("fl_never_valid", 32'(seen_valid), 32'd0);
      run_op("fl_after_ctz", 2'b00, 32'h0000_0004, 5'd15);

      // Async reset mid-CALC, asserted between clock edges.
      issue(2'b10, 32'hFFFF_FFFF, 5'd16);
      step();
      step();
      #2 reset_n = 1'b0;
      #1;
      check("ar_out_valid", 32'(out_valid), 32'd0);
      check("ar_out_result", out_result, 32'd0);
      check("ar_out_tag", 32'(out_tag), 32'd0);
      check("ar_busy", 32'(busy), 32'd0);
      step();
      #2 reset_n = 1'b1;
      step();
      run_op("ar_clz1", 2'b01, 32'h0000_0001, 5'd17);

      // Random ops: mix of dense, sparse and single-bit operands.
      for (int n = 0; n < 40; n++) begin
         rop = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 2))
            0:       rx = $urandom;
            1:       rx = $urandom & $urandom & $urandom;
            default: rx = 32'd1 << $urandom_range(0, 31);
         endcase
         run_op("rand", rop, rx, 5'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
